int_mult_result_buffer: RTL and testbench

Result queue placed directly downstream of the shared-APU integer multiplier wrapper. It captures each valid multiplier result with its tag and status, holds it in a small FIFO, and presents it to the result interconnect with a valid/ack handshake. The multiplier issues unconditionally, so this buffer supplies the backpressure (`Ready_o`) that the APU arbiter uses to stop issuing.

---
 rtl/apu_package.sv | 22 ++
 rtl/apu_sync_fifo.sv | 94 +++++++++
 rtl/int_mult_result_buffer.sv | 72 +++++++
 tb/tb_int_mult_result_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apu_package.sv
// Shared APU definitions: datapath widths and the integer multiplier result
// entry that the multiplier wrapper, its result buffer and the result
// interconnect all exchange.
package apu_package;

    // Width of a DSP/integer multiplier result word.
    localparam int DSP_WIDTH = 32;

    // Width of the APU transaction tag carried alongside every result.
    localparam int WAPUTAG = 5;

    // Width of the multiplier status field.
    localparam int INT_MULT_STATUS_WIDTH = 2;

    // One multiplier result as it travels from the wrapper to the interconnect.
    typedef struct packed {
        logic [DSP_WIDTH-1:0]             res;
        logic [WAPUTAG-1:0]               tag;
        logic [INT_MULT_STATUS_WIDTH-1:0] status;
    } int_mult_result_t;

endpackage

// File: rtl/apu_sync_fifo.sv
// Generic single-clock FIFO. Pointers wrap explicitly at DEPTH-1, so any
// DEPTH >= 1 works, including non-powers of two. Storage is not reset; the
// read port is forced to zero while empty so it never shows stale contents.
module apu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(DEPTH+1);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] occupancy;
    logic                   push;
    logic                   pop;

    // Full and empty come from the registered occupancy only, so a same-cycle
    // read never opens room for a write.
    always_comb begin
        full  = (occupancy == COUNT_WIDTH'(DEPTH));
        empty = (occupancy == '0);
        push  = wr_en && !full;
        pop   = rd_en && !empty;
    end

    // Write pointer advances on each accepted write and wraps after DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            if (wr_ptr == PTR_WIDTH'(DEPTH-1)) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
        end
    end

    // Read pointer advances on each accepted read and wraps after DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            if (rd_ptr == PTR_WIDTH'(DEPTH-1)) begin
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
        end
    end

    // Occupancy moves only on a lone write or a lone read.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + COUNT_WIDTH'(1);
                2'b01:   occupancy <= occupancy - COUNT_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Entry storage is written without reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head entry is presented directly from storage, zeroed while empty.
    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = mem[rd_ptr];
        end
    end

    assign count = occupancy;

endmodule

// File: rtl/int_mult_result_buffer.sv
// Result queue behind the shared-APU integer multiplier. The multiplier issues
// without looking, so Ready_o is what throttles the arbiter; anything that
// arrives while full is dropped and flagged in a sticky overflow bit.
module int_mult_result_buffer
    import apu_package::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = DSP_WIDTH,
    parameter int TAG_WIDTH  = WAPUTAG
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       Valid_i,
    input  logic [DATA_WIDTH-1:0]      Res_i,
    input  logic [TAG_WIDTH-1:0]       Tag_i,
    input  logic [1:0]                 Status_i,
    output logic                       Ready_o,
    output logic                       Valid_o,
    output logic [DATA_WIDTH-1:0]      Res_o,
    output logic [TAG_WIDTH-1:0]       Tag_o,
    output logic [1:0]                 Status_o,
    input  logic                       Ack_i,
    output logic [$clog2(DEPTH+1)-1:0] Count_o,
    output logic                       Overflow_o
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + TAG_WIDTH + 2;

    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic [ENTRY_WIDTH-1:0] rd_entry;
    logic                   full;
    logic                   empty;
    logic                   overflow;

    assign wr_entry = {Res_i, Tag_i, Status_i};

    apu_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (Valid_i),
        .wr_data (wr_entry),
        .rd_en   (Ack_i),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (Count_o)
    );

    // Handshake flags and head-entry fields unpacked from the FIFO read port.
    always_comb begin
        Ready_o  = !full;
        Valid_o  = !empty;
        Res_o    = rd_entry[ENTRY_WIDTH-1 -: DATA_WIDTH];
        Tag_o    = rd_entry[TAG_WIDTH+1 -: TAG_WIDTH];
        Status_o = rd_entry[1:0];
    end

    // A result offered while full is lost; remember that until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (Valid_i && full) begin
            overflow <= 1'b1;
        end
    end

    assign Overflow_o = overflow;

endmodule

// File: tb/tb_int_mult_result_buffer.sv
// Bench for int_mult_result_buffer: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_int_mult_result_buffer;
    import apu_package::*;

    localparam int DEPTH = 2;
    localparam int DW    = DSP_WIDTH;
    localparam int TW    = WAPUTAG;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] res_in = '0;
    logic [TW-1:0] tag_in = '0;
    logic [1:0]    status_in = '0;
    logic          ack = 1'b0;
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] res_out;
    logic [TW-1:0] tag_out;
    logic [1:0]    status_out;
    logic [CW-1:0] count_out;
    logic          overflow_out;

    int checks = 0;
    int errors = 0;
    bit checkEnable = 1'b0;

    int_mult_result_t modelQ[$];
    bit               modelOverflow = 1'b0;
    bit               modelWasFull;
    bit               modelHadHead;
    logic [TW-1:0]    emitted[$];

    always #5 clk = ~clk;

    int_mult_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .Valid_i    (valid_in),
        .Res_i      (res_in),
        .Tag_i      (tag_in),
        .Status_i   (status_in),
        .Ready_o    (ready_out),
        .Valid_o    (valid_out),
        .Res_o      (res_out),
        .Tag_o      (tag_out),
        .Status_o   (status_out),
        .Ack_i      (ack),
        .Count_o    (count_out),
        .Overflow_o (overflow_out)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the next edge.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] r, input logic [TW-1:0] t,
                                 input logic [1:0] s, input bit a);
        valid_in  = v;
        res_in    = r;
        tag_in    = t;
        status_in = s;
        ack       = a;
        @(posedge clk);
        #2;
    endtask

    // Model: a FIFO of at most DEPTH entries; full refuses input even when popping.
    always @(posedge clk) begin
        if (rst) begin
            modelQ.delete();
            modelOverflow = 1'b0;
        end else begin
            modelWasFull = (modelQ.size() == DEPTH);
            modelHadHead = (modelQ.size() != 0);
            if (valid_in && modelWasFull) modelOverflow = 1'b1;
            if (modelHadHead && ack) void'(modelQ.pop_front());
            if (valid_in && !modelWasFull)
                modelQ.push_back('{res: res_in, tag: tag_in, status: status_in});
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("ready", 64'(ready_out), 64'(modelQ.size() != DEPTH));
            checkOutput("valid", 64'(valid_out), 64'(modelQ.size() != 0));
            checkOutput("count", 64'(count_out), 64'(modelQ.size()));
            checkOutput("overflow", 64'(overflow_out), 64'(modelOverflow));
            if (modelQ.size() != 0) begin
                checkOutput("head_res", 64'(res_out), 64'(modelQ[0].res));
                checkOutput("head_tag", 64'(tag_out), 64'(modelQ[0].tag));
                checkOutput("head_status", 64'(status_out), 64'(modelQ[0].status));
            end
            if (valid_out && ack) emitted.push_back(tag_out);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int drain;

        // Reset held two cycles while the multiplier claims a valid result.
        rst = 1'b1;
        applyStimulus(1, 32'hdead_beef, 5'd5, 2'd1, 0);
        applyStimulus(1, 32'hdead_beef, 5'd5, 2'd1, 0);
        rst = 1'b0;
        checkEnable = 1'b1;
        checkOutput("reset_ready", 64'(ready_out), 64'd1);
        checkOutput("reset_valid", 64'(valid_out), 64'd0);
        checkOutput("reset_count", 64'(count_out), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_out), 64'd0);
        applyStimulus(0, '0, '0, 2'd0, 0);
        checkOutput("reset_nothing_stored", 64'(count_out), 64'd0);

        // Single result: visible one cycle after the push, gone after ack.
        applyStimulus(1, 32'h0000_0006, 5'd3, 2'd2, 0);
        checkOutput("single_valid", 64'(valid_out), 64'd1);
        checkOutput("single_res", 64'(res_out), 64'd6);
        checkOutput("single_tag", 64'(tag_out), 64'd3);
        checkOutput("single_status", 64'(status_out), 64'd2);
        applyStimulus(0, '0, '0, 2'd0, 0);
        checkOutput("single_hold", 64'(valid_out), 64'd1);
        applyStimulus(0, '0, '0, 2'd0, 1);
        checkOutput("single_popped", 64'(valid_out), 64'd0);

        // Fill, overflow attempt with tag 7, then drain in order.
        emitted.delete();
        applyStimulus(1, 32'h11, 5'd1, 2'd0, 0);
        applyStimulus(1, 32'h22, 5'd2, 2'd0, 0);
        checkOutput("fill_ready", 64'(ready_out), 64'd0);
        checkOutput("fill_count", 64'(count_out), 64'd2);
        applyStimulus(1, 32'h77, 5'd7, 2'd3, 0);
        checkOutput("ovf_flag", 64'(overflow_out), 64'd1);
        checkOutput("ovf_count", 64'(count_out), 64'd2);
        checkOutput("ovf_head", 64'(tag_out), 64'd1);
        applyStimulus(0, '0, '0, 2'd0, 1);
        checkOutput("drain1_ready", 64'(ready_out), 64'd1);
        checkOutput("drain1_head", 64'(tag_out), 64'd2);
        applyStimulus(0, '0, '0, 2'd0, 1);
        checkOutput("drain2_valid", 64'(valid_out), 64'd0);
        checkOutput("order_len", 64'(emitted.size()), 64'd2);
        if (emitted.size() == 2) begin
            checkOutput("order_first", 64'(emitted[0]), 64'd1);
            checkOutput("order_second", 64'(emitted[1]), 64'd2);
        end
        checkOutput("ovf_sticky", 64'(overflow_out), 64'd1);

        // Full with simultaneous pop: push is still refused.
        applyStimulus(1, 32'h33, 5'd3, 2'd0, 0);
        applyStimulus(1, 32'h44, 5'd4, 2'd0, 0);
        applyStimulus(1, 32'h88, 5'd8, 2'd0, 1);
        checkOutput("full_pop_count", 64'(count_out), 64'd1);
        checkOutput("full_pop_head", 64'(tag_out), 64'd4);
        checkOutput("full_pop_ready", 64'(ready_out), 64'd1);
        applyStimulus(0, '0, '0, 2'd0, 1);

        // Empty with push and ack together: ack ignored.
        applyStimulus(1, 32'h55, 5'd6, 2'd1, 1);
        checkOutput("empty_push_ack_count", 64'(count_out), 64'd1);
        applyStimulus(0, '0, '0, 2'd0, 1);

        // Reset clears the sticky overflow.
        rst = 1'b1;
        applyStimulus(0, '0, '0, 2'd0, 0);
        rst = 1'b0;
        checkOutput("ovf_cleared", 64'(overflow_out), 64'd0);

        // Streaming: 20 results with ack held high.
        emitted.delete();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, DW'(i * 3 + 1), TW'(i), 2'(i % 4), 1);
        end
        drain = 0;
        while (valid_out && drain < 10) begin
            applyStimulus(0, '0, '0, 2'd0, 1);
            drain++;
        end
        checkOutput("stream_drained", 64'(valid_out), 64'd0);
        checkOutput("stream_len", 64'(emitted.size()), 64'd20);
        for (int i = 0; i < 20 && i < emitted.size(); i++) begin
            checkOutput("stream_tag", 64'(emitted[i]), 64'(i));
        end
        checkOutput("stream_overflow", 64'(overflow_out), 64'd0);

        // Reset with data held, then tag 9 must be the first output.
        applyStimulus(1, 32'hA, 5'd10, 2'd0, 0);
        applyStimulus(1, 32'hB, 5'd11, 2'd0, 0);
        checkOutput("rwd_count", 64'(count_out), 64'd2);
        rst = 1'b1;
        applyStimulus(0, '0, '0, 2'd0, 0);
        rst = 1'b0;
        checkOutput("rwd_valid", 64'(valid_out), 64'd0);
        checkOutput("rwd_count_zero", 64'(count_out), 64'd0);
        applyStimulus(1, 32'h9, 5'd9, 2'd0, 0);
        checkOutput("rwd_first_tag", 64'(tag_out), 64'd9);
        checkOutput("rwd_first_res", 64'(res_out), 64'd9);
        applyStimulus(0, '0, '0, 2'd0, 1);
        applyStimulus(0, '0, '0, 2'd0, 0);

        checkEnable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
